// File: rtl/sdr_dsp_pkg.sv
// Shared definitions for the SDR demodulator blocks: FSM state encoding,
// a clog2 helper and the square-root width rule.
package sdr_dsp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SQ_I  = 3'd1,
        ST_SQ_Q  = 3'd2,
        ST_ROOT  = 3'd3,
        ST_FINAL = 3'd4,
        ST_DONE  = 3'd5
    } demod_state_t;

    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < value) begin
                result = k + 1;
            end
        end
        return result;
    endfunction

    // One extra root bit is produced when the result is to be rounded.
    function automatic int root_width(input int w, input int f, input int rnd);
        return w + f + rnd;
    endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Bit-serial non-restoring integer square root of a 2R-bit radicand.
// One root bit per cycle, MSB first; the first bit is resolved on the start edge.
module isqrt_seq
    import sdr_dsp_pkg::*;
#(
    parameter int R = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*R-1:0]   radicand,
    output logic             busy,
    output logic             done,
    output logic [R-1:0]     root
);

    localparam int REM_W = R + 5;
    localparam int CNT_W = (clog2_f(R) < 1) ? 1 : clog2_f(R);

    logic [2*R-1:0]          r_rad;
    logic signed [REM_W-1:0] r_rem;
    logic [R-1:0]            r_root;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_step;
    logic [2*R-1:0]          w_src_rad;
    logic signed [REM_W-1:0] w_src_rem;
    logic [R-1:0]            w_src_root;
    logic signed [REM_W-1:0] w_shift;
    logic signed [REM_W-1:0] w_trial;
    logic signed [REM_W-1:0] w_next_rem;
    logic [R-1:0]            w_next_root;

    assign w_step = start || r_busy;

    // One non-restoring iteration: subtract 4Q+1 on a non-negative remainder, else add 4Q+3
    always_comb begin
        w_src_rad  = r_rad;
        w_src_rem  = r_rem;
        w_src_root = r_root;
        if (start && !r_busy) begin
            w_src_rad  = radicand;
            w_src_rem  = '0;
            w_src_root = '0;
        end else begin
            w_src_rad  = r_rad;
        end
        w_shift = {w_src_rem[REM_W-3:0], w_src_rad[2*R-1 -: 2]};
        if (!w_src_rem[REM_W-1]) begin
            w_trial    = {3'b000, w_src_root, 2'b01};
            w_next_rem = w_shift - w_trial;
        end else begin
            w_trial    = {3'b000, w_src_root, 2'b11};
            w_next_rem = w_shift + w_trial;
        end
        w_next_root = {w_src_root[R-2:0], ~w_next_rem[REM_W-1]};
    end

    // Iteration registers and the remaining-bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rad  <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_step) begin
                r_rad  <= w_src_rad << 2;
                r_rem  <= w_next_rem;
                r_root <= w_next_root;
                if (r_busy) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end else begin
                    r_cnt  <= CNT_W'(R - 1);
                    r_busy <= (R > 1);
                    r_done <= (R == 1);
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign root = r_root;

endmodule

// File: rtl/am_demod_seq.sv
// Sequential AM envelope detector: sqrt(I^2 + Q^2) with fractional bits and
// optional round-half-up, using one shared multiplier and a bit-serial root.
module am_demod_seq
    import sdr_dsp_pkg::*;
#(
    parameter int INPUT_WIDTH = 12,
    parameter int FRAC_BITS   = 2,
    parameter int ROUND       = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [INPUT_WIDTH-1:0]     inphase,
    input  logic signed [INPUT_WIDTH-1:0]     quadrature,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [INPUT_WIDTH+FRAC_BITS-1:0]  amdemod_out
);

    localparam int W     = INPUT_WIDTH;
    localparam int OUT_W = INPUT_WIDTH + FRAC_BITS;
    localparam int R     = root_width(INPUT_WIDTH, FRAC_BITS, ROUND);
    localparam int SUM_W = 2 * W;
    localparam int RAD_W = 2 * R;
    localparam int SHIFT = 2 * (FRAC_BITS + ROUND);
    localparam int CNT_W = (clog2_f(R) < 1) ? 1 : clog2_f(R);

    demod_state_t            r_state;
    demod_state_t            w_next_state;
    logic signed [W-1:0]     r_i;
    logic signed [W-1:0]     r_q;
    logic [SUM_W-1:0]        r_sum;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [OUT_W-1:0]        r_out;
    logic                    r_out_valid;
    logic                    r_in_ready;

    logic                    w_accept;
    logic signed [W-1:0]     w_mul_op;
    logic signed [SUM_W-1:0] w_prod;
    logic [SUM_W-1:0]        w_prod_u;
    logic [RAD_W-1:0]        w_radicand;
    logic                    w_sqrt_start;
    logic                    w_sqrt_busy;
    logic                    w_sqrt_done;
    logic [R-1:0]            w_root;
    logic [OUT_W-1:0]        w_res;

    assign w_accept   = in_valid && r_in_ready;
    assign w_mul_op   = (r_state == ST_SQ_Q) ? r_q : r_i;
    assign w_prod     = w_mul_op * w_mul_op;
    assign w_prod_u   = w_prod;
    assign w_radicand = RAD_W'(r_sum) << SHIFT;
    assign w_sqrt_start = (r_state == ST_ROOT) && (r_bit_cnt == CNT_W'(R - 1)) && !w_sqrt_busy;

    isqrt_seq #(.R(R)) u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (w_sqrt_start),
        .radicand (w_radicand),
        .busy     (w_sqrt_busy),
        .done     (w_sqrt_done),
        .root     (w_root)
    );

    generate
        if (ROUND != 0) begin : g_round
            logic [OUT_W:0] w_rnd;
            assign w_rnd = {1'b0, w_root[R-1:1]} + {{OUT_W{1'b0}}, w_root[0]};
            assign w_res = w_rnd[OUT_W] ? {OUT_W{1'b1}} : w_rnd[OUT_W-1:0];
        end else begin : g_trunc
            assign w_res = w_root;
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = ST_SQ_I; else w_next_state = ST_IDLE;
            ST_SQ_I:  w_next_state = ST_SQ_Q;
            ST_SQ_Q:  w_next_state = ST_ROOT;
            ST_ROOT:  if (r_bit_cnt == '0) w_next_state = ST_FINAL; else w_next_state = ST_ROOT;
            ST_FINAL: if (w_sqrt_done) w_next_state = ST_DONE; else w_next_state = ST_FINAL;
            ST_DONE:  if (out_ready) w_next_state = ST_IDLE; else w_next_state = ST_DONE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: sample capture, accumulate squares, bit counter, output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i         <= '0;
            r_q         <= '0;
            r_sum       <= '0;
            r_bit_cnt   <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_in_ready <= (w_next_state == ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_i <= inphase;
                        r_q <= quadrature;
                    end
                end
                ST_SQ_I: r_sum <= w_prod_u;
                ST_SQ_Q: begin
                    r_sum     <= r_sum + w_prod_u;
                    r_bit_cnt <= CNT_W'(R - 1);
                end
                ST_ROOT: begin
                    if (r_bit_cnt != '0) begin
                        r_bit_cnt <= r_bit_cnt - CNT_W'(1);
                    end
                end
                ST_FINAL: begin
                    if (w_sqrt_done) begin
                        r_out       <= w_res;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign amdemod_out = r_out;

endmodule

// File: tb/tb_am_demod_seq.sv
// Directed and randomised check of am_demod_seq, rounded (default) and truncating variants.
module tb_am_demod_seq;

    logic        clk;
    logic        rst;
    logic        in_valid_m, in_valid_t;
    logic        in_ready_m, in_ready_t;
    logic signed [11:0] inphase, quadrature;
    logic        out_valid_m, out_valid_t;
    logic        out_ready_m, out_ready_t;
    logic [13:0] out_m, out_t;

    int n_checks;
    int n_fail;

    am_demod_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid_m),
        .in_ready    (in_ready_m),
        .inphase     (inphase),
        .quadrature  (quadrature),
        .out_valid   (out_valid_m),
        .out_ready   (out_ready_m),
        .amdemod_out (out_m)
    );

    am_demod_seq #(.ROUND(0)) dut_t (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid_t),
        .in_ready    (in_ready_t),
        .inphase     (inphase),
        .quadrature  (quadrature),
        .out_valid   (out_valid_t),
        .out_ready   (out_ready_t),
        .amdemod_out (out_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint isqrt_model(input longint s);
        longint lo, hi, mid;
        lo = 0;
        hi = 65536;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= s) lo = mid; else hi = mid;
        end
        return lo;
    endfunction

    // Push one sample into both variants and check latency and result of each.
    task automatic run_sample(input int i, input int q, input int exp_m, input int exp_t, input string tag);
        int lat_m, lat_t;
        logic [13:0] v_m, v_t;
        lat_m = 0;
        lat_t = 0;
        v_m = '0;
        v_t = '0;
        @(negedge clk);
        inphase    = 12'(i);
        quadrature = 12'(q);
        in_valid_m = 1'b1;
        in_valid_t = 1'b1;
        check_val({tag, "_in_ready"}, {31'd0, in_ready_m & in_ready_t}, 32'd1);
        @(posedge clk);
        #1;
        in_valid_m = 1'b0;
        in_valid_t = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (lat_m == 0 && out_valid_m) begin lat_m = cyc; v_m = out_m; end
            if (lat_t == 0 && out_valid_t) begin lat_t = cyc; v_t = out_t; end
            if (lat_m != 0 && lat_t != 0) break;
        end
        check_val({tag, "_lat_round"}, 32'(lat_m), 32'd18);
        check_val({tag, "_lat_trunc"}, 32'(lat_t), 32'd17);
        check_val({tag, "_round"}, {18'd0, v_m}, 32'(exp_m));
        check_val({tag, "_trunc"}, {18'd0, v_t}, 32'(exp_t));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        int ri, rq;
        longint s;
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        in_valid_m  = 1'b0;
        in_valid_t  = 1'b0;
        inphase     = '0;
        quadrature  = '0;
        out_ready_m = 1'b1;
        out_ready_t = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_in_ready", {30'd0, in_ready_m, in_ready_t}, 32'd3);
        check_val("rst_out_valid", {30'd0, out_valid_m, out_valid_t}, 32'd0);
        check_val("rst_out_round", {18'd0, out_m}, 32'd0);
        check_val("rst_out_trunc", {18'd0, out_t}, 32'd0);

        run_sample(3, 4, 20, 20, "i3q4");
        run_sample(-2048, -2048, 11585, 11585, "neg_full");
        run_sample(1, 1, 6, 5, "i1q1");
        run_sample(0, 0, 0, 0, "zero");
        run_sample(-2048, 0, 8192, 8192, "neg_i");
        run_sample(2047, 2047, 11580, 11579, "pos_full");
        run_sample(3, 3, 17, 16, "i3q3");
        run_sample(1, 2, 9, 8, "i1q2");
        run_sample(-7, 24, 100, 100, "i7q24");
        run_sample(2047, -2048, 11582, 11582, "mixed_full");

        // Backpressure on the rounded instance; a new request must be ignored.
        @(negedge clk);
        inphase = 12'sd3;
        quadrature = 12'sd4;
        in_valid_m = 1'b1;
        out_ready_m = 1'b0;
        @(posedge clk);
        #1;
        in_valid_m = 1'b0;
        seen = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (out_valid_m) begin seen = 1; break; end
        end
        check_val("bp_valid_seen", 32'(seen), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            inphase = 12'sd100;
            quadrature = 12'sd0;
            in_valid_m = 1'b1;
            @(posedge clk);
            #1;
            check_val("bp_hold_valid", {31'd0, out_valid_m}, 32'd1);
            check_val("bp_hold_value", {18'd0, out_m}, 32'd20);
            check_val("bp_in_ready", {31'd0, in_ready_m}, 32'd0);
        end
        @(negedge clk);
        in_valid_m = 1'b0;
        out_ready_m = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_release_valid", {31'd0, out_valid_m}, 32'd0);
        check_val("bp_release_ready", {31'd0, in_ready_m}, 32'd1);
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid_m) seen = 1;
        end
        check_val("bp_no_ghost", 32'(seen), 32'd0);

        // Reset during ROOT aborts the sample.
        @(negedge clk);
        inphase = 12'sd5;
        quadrature = 12'sd12;
        in_valid_m = 1'b1;
        in_valid_t = 1'b1;
        @(posedge clk);
        #1;
        in_valid_m = 1'b0;
        in_valid_t = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("mid_rst_valid", {30'd0, out_valid_m, out_valid_t}, 32'd0);
        check_val("mid_rst_ready", {30'd0, in_ready_m, in_ready_t}, 32'd3);
        check_val("mid_rst_out", {18'd0, out_m}, 32'd0);
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid_m || out_valid_t) seen = 1;
        end
        check_val("mid_rst_aborted", 32'(seen), 32'd0);
        run_sample(3, 4, 20, 20, "post_rst");

        // Random samples against an independent integer square-root model.
        for (int n = 0; n < 200; n++) begin
            ri = int'($urandom_range(4095, 0)) - 2048;
            rq = int'($urandom_range(4095, 0)) - 2048;
            s = longint'(ri) * ri + longint'(rq) * rq;
            run_sample(ri, rq, int'((isqrt_model(s * 64) + 1) / 2), int'(isqrt_model(s * 16)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
